// File: rtl/alu_cmd_dispatcher.sv
// Pops packed ALU commands, runs them through the ALU start/done handshake, pushes {id, result}.
// Optional watchdog on the ALU wait: define ALU_CMD_TIMEOUT_EN.
module alu_cmd_dispatcher #(
    parameter int DATA_SIZE      = 16,
    parameter int ID_SIZE        = 8,
    parameter int OPERATION_SIZE = 2,
    parameter int FIFO_IN_WIDTH  = 2*DATA_SIZE+ID_SIZE+OPERATION_SIZE,
    parameter int RESULT_SIZE    = DATA_SIZE+1,
    parameter int FIFO_OUT_WIDTH = ID_SIZE+RESULT_SIZE,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fifo_in_empty,
    input  logic [FIFO_IN_WIDTH-1:0]  fifo_in_rdata,
    output logic                      fifo_in_r_en,
    output logic [OPERATION_SIZE-1:0] alu_op,
    output logic [DATA_SIZE-1:0]      alu_a,
    output logic [DATA_SIZE-1:0]      alu_b,
    output logic                      alu_start,
    input  logic                      alu_done,
    input  logic [RESULT_SIZE-1:0]    alu_result,
    input  logic                      fifo_out_full,
    output logic                      fifo_out_w_en,
    output logic [FIFO_OUT_WIDTH-1:0] fifo_out_wdata,
    output logic                      busy,
    output logic [15:0]               cmd_count
`ifdef ALU_CMD_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_ISSUE,
        S_WAIT,
        S_PUSH
    } state_t;

    localparam int ID_LO = OPERATION_SIZE;
    localparam int D0_LO = OPERATION_SIZE + ID_SIZE;
    localparam int D1_LO = D0_LO + DATA_SIZE;

    state_t                    state;
    logic [OPERATION_SIZE-1:0] op_q;
    logic [ID_SIZE-1:0]        id_q;
    logic [DATA_SIZE-1:0]      a_q;
    logic [DATA_SIZE-1:0]      b_q;
    logic [FIFO_OUT_WIDTH-1:0] out_q;

`ifdef ALU_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            out_q     <= '0;
            cmd_count <= '0;
`ifdef ALU_CMD_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!fifo_in_empty)
                        state <= S_READ;
                end
                S_READ: begin
                    state <= S_CAPTURE;
                end
                // Read data is valid only the cycle after the pop strobe
                S_CAPTURE: begin
                    op_q  <= fifo_in_rdata[OPERATION_SIZE-1:0];
                    id_q  <= fifo_in_rdata[ID_LO +: ID_SIZE];
                    a_q   <= fifo_in_rdata[D0_LO +: DATA_SIZE];
                    b_q   <= fifo_in_rdata[D1_LO +: DATA_SIZE];
                    state <= S_CAPTURE == S_CAPTURE ? S_ISSUE : S_IDLE;
                end
                S_ISSUE: begin
`ifdef ALU_CMD_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        out_q <= {id_q, alu_result};
                        state <= S_PUSH;
                    end
`ifdef ALU_CMD_TIMEOUT_EN
                    // A real result on the expiry cycle takes priority
                    else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        out_q       <= {id_q, {RESULT_SIZE{1'b1}}};
                        timeout_err <= 1'b1;
                        state       <= S_PUSH;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                S_PUSH: begin
                    if (!fifo_out_full) begin
                        cmd_count <= cmd_count + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fifo_in_r_en   = (state == S_READ);
    assign alu_start      = (state == S_ISSUE);
    assign fifo_out_w_en  = (state == S_PUSH) && !fifo_out_full;
    assign busy           = (state != S_IDLE);
    assign alu_op         = op_q;
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign fifo_out_wdata = out_q;

endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
// Directed bench for alu_cmd_dispatcher: FIFO_IN model, ALU responder, push monitor.
// Build with ALU_CMD_TIMEOUT_EN to also exercise the watchdog.
module tb_alu_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_in_empty = 1'b1;
    logic [41:0] fifo_in_rdata = '0;
    logic        fifo_in_r_en;
    logic [1:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [16:0] alu_result = '0;
    logic        fifo_out_full = 1'b0;
    logic        fifo_out_w_en;
    logic [24:0] fifo_out_wdata;
    logic        busy;
    logic [15:0] cmd_count;
`ifdef ALU_CMD_TIMEOUT_EN
    logic        timeout_err;
`endif

    alu_cmd_dispatcher dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_in_empty  (fifo_in_empty),
        .fifo_in_rdata  (fifo_in_rdata),
        .fifo_in_r_en   (fifo_in_r_en),
        .alu_op         (alu_op),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_start      (alu_start),
        .alu_done       (alu_done),
        .alu_result     (alu_result),
        .fifo_out_full  (fifo_out_full),
        .fifo_out_w_en  (fifo_out_w_en),
        .fifo_out_wdata (fifo_out_wdata),
        .busy           (busy),
        .cmd_count      (cmd_count)
`ifdef ALU_CMD_TIMEOUT_EN
        ,
        .timeout_err    (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // FIFO_IN model: word appears on rdata the cycle after the pop strobe
    logic [41:0] fq[$];
    initial begin
        forever begin
            @(negedge clk);
            fifo_in_empty = (fq.size() == 0);
            #3;
            if (fifo_in_r_en && fq.size() > 0) begin
                @(posedge clk);
                #1;
                fifo_in_rdata = fq.pop_front();
            end
        end
    end

    // ALU responder: done arrives alu_lat cycles after the start cycle
    int   alu_lat = 1;
    logic alu_mute = 1'b0;
    initial begin
        logic [15:0] ra, rb;
        logic [1:0]  rop;
        forever begin
            @(negedge clk);
            if (alu_start && !alu_mute) begin
                ra  = alu_a;
                rb  = alu_b;
                rop = alu_op;
                repeat (alu_lat) @(negedge clk);
                case (rop)
                    2'd0: alu_result = {1'b0, ra} + {1'b0, rb};
                    2'd1: alu_result = {1'b0, ra} - {1'b0, rb};
                    2'd2: alu_result = {1'b0, ra & rb};
                    default: alu_result = {1'b0, ra ^ rb};
                endcase
                alu_done = 1'b1;
                @(negedge clk);
                alu_done = 1'b0;
            end
        end
    end

    // Push / strobe monitor
    logic [24:0] push_q[$];
    int          gaps_q[$];
    int          idle_gap = 0;
    int          n_push = 0;
    int          n_start = 0;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) n_start = n_push;
            if (fifo_in_r_en) chk("pop_while_empty", fifo_in_empty, 0);
            if (alu_start) begin
                chk("outstanding_start", n_start - n_push, 0);
                n_start++;
            end
            if (fifo_out_w_en) begin
                chk("push_while_full", fifo_out_full, 0);
                push_q.push_back(fifo_out_wdata);
                gaps_q.push_back(idle_gap);
                idle_gap = 0;
                n_push++;
            end else if (!busy) begin
                idle_gap++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d0;
        logic [7:0]  id;
        logic [1:0]  op;
        int          lat;
        int          full;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int np;
        int cnt;
        tbl[0] = '{16'h0003, 16'h0005, 8'h2A, 2'd0, 2, 0,  25'h0540008};
        tbl[1] = '{16'h0001, 16'hFFFF, 8'hFF, 2'd0, 1, 0,  25'h1FF0000};
        tbl[2] = '{16'h00F0, 16'h0F0F, 8'h11, 2'd3, 3, 10, 25'h0220FFF};
        tbl[3] = '{16'h0020, 16'h0010, 8'h7E, 2'd1, 4, 2,  25'h0FDFFF0};

        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_r_en", fifo_in_r_en, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_w_en", fifo_out_w_en, 0);
        chk("rst_count", cmd_count, 0);
        chk("rst_wdata", fifo_out_wdata, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            alu_lat = tbl[i].lat;
            fifo_out_full = (tbl[i].full > 0);
            fq.push_back({tbl[i].d1, tbl[i].d0, tbl[i].id, tbl[i].op});
            for (int t = 0; t < 100 && !alu_done; t++) tick();
            chk("done_seen", alu_done, 1);
            chk("alu_a", alu_a, tbl[i].d0);
            chk("alu_b", alu_b, tbl[i].d1);
            chk("alu_op", alu_op, tbl[i].op);
            tick();
            for (int f = 0; f < tbl[i].full; f++) begin
                chk("bp_w_en", fifo_out_w_en, 0);
                chk("bp_wdata", fifo_out_wdata, tbl[i].exp);
                chk("bp_busy", busy, 1);
                tick();
            end
            fifo_out_full = 1'b0;
            #1;
            chk("push_w_en", fifo_out_w_en, 1);
            chk("push_wdata", fifo_out_wdata, tbl[i].exp);
            tick();
            chk("post_busy", busy, 0);
            chk("post_count", cmd_count, i + 1);
            chk("post_wdata_hold", fifo_out_wdata, tbl[i].exp);
        end
        chk("single_pushes", n_push, 4);

        // Three queued commands back to back
        push_q.delete();
        gaps_q.delete();
        alu_lat = 1;
        for (int i = 1; i <= 3; i++)
            fq.push_back({16'h0010, 16'(i), 8'(i), 2'd0});
        for (int t = 0; t < 200 && push_q.size() < 3; t++) tick();
        chk("b2b_pushes", push_q.size(), 3);
        if (push_q.size() == 3) begin
            chk("b2b_0", push_q[0], 25'h0020011);
            chk("b2b_1", push_q[1], 25'h0040012);
            chk("b2b_2", push_q[2], 25'h0060013);
            chk("b2b_gap1", gaps_q[1], 1);
            chk("b2b_gap2", gaps_q[2], 1);
        end
        tick();
        chk("b2b_count", cmd_count, 7);

`ifdef ALU_CMD_TIMEOUT_EN
        chk("tmo_err_init", timeout_err, 0);
        alu_mute = 1'b1;
        fq.push_back({16'h0002, 16'h0001, 8'h55, 2'd0});
        for (int t = 0; t < 50 && !alu_start; t++) tick();
        chk("tmo_start", alu_start, 1);
        cnt = 0;
        for (int t = 0; t < 200 && !fifo_out_w_en; t++) begin
            tick();
            cnt++;
        end
        chk("tmo_cycles", cnt, 65);
        chk("tmo_w_en", fifo_out_w_en, 1);
        chk("tmo_wdata", fifo_out_wdata, 25'h0ABFFFF);
        chk("tmo_err", timeout_err, 1);
        repeat (5) tick();
        chk("tmo_err_sticky", timeout_err, 1);
        alu_mute = 1'b0;
`endif

        // Reset while waiting on the ALU; the late done must be ignored
        alu_lat = 20;
        fq.push_back({16'h0001, 16'h0002, 8'h33, 2'd0});
        for (int t = 0; t < 50 && !alu_start; t++) tick();
        chk("mid_start", alu_start, 1);
        repeat (3) tick();
        chk("mid_busy_pre", busy, 1);
        np = n_push;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_r_en", fifo_in_r_en, 0);
        chk("mid_start0", alu_start, 0);
        chk("mid_w_en", fifo_out_w_en, 0);
        chk("mid_count", cmd_count, 0);
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("mid_no_push", n_push, np);
        chk("mid_idle", busy, 0);
`ifdef ALU_CMD_TIMEOUT_EN
        chk("mid_tmo_clr", timeout_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
